// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// Imported by the interface, the FIFO and the top.
package wb_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic              killed;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_FIFO
  } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency sources,
// decode hazard query and the regfile write port.
interface wb_arbiter_if #(
  parameter int CW = 3
);
  import wb_arbiter_pkg::*;

  logic              p_valid;
  logic              p_wen;
  logic [ADDR_W-1:0] p_rd;
  logic [DATA_W-1:0] p_data;
  logic              p_stall;

  logic              l_valid;
  logic              l_ready;
  logic [ADDR_W-1:0] l_rd;
  logic [DATA_W-1:0] l_data;

  logic [ADDR_W-1:0] q_rs;
  logic [ADDR_W-1:0] q_rt;
  logic              q_rs_busy;
  logic              q_rt_busy;

  logic [ADDR_W-1:0] W_write_rd;
  logic [DATA_W-1:0] W_write_data;
  logic              W_en;
  logic [CW-1:0]     fifo_count;

  modport slave (
    input  p_valid, p_wen, p_rd, p_data,
    input  l_valid, l_rd, l_data,
    input  q_rs, q_rt,
    output p_stall, l_ready,
    output q_rs_busy, q_rt_busy,
    output W_write_rd, W_write_data, W_en,
    output fifo_count
  );

  modport master (
    output p_valid, p_wen, p_rd, p_data,
    output l_valid, l_rd, l_data,
    output q_rs, q_rt,
    input  p_stall, l_ready,
    input  q_rs_busy, q_rt_busy,
    input  W_write_rd, W_write_data, W_en,
    input  fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency results with
// kill-by-rd and a parallel rd match for hazards.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_rd,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output wb_entry_t         head,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              rs_hit,
  output logic              rt_hit
);

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // a same-cycle push lands in a free slot, so it is never killed
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && mem[i].valid && mem[i].rd == kill_rd)
          mem[i].killed <= 1'b1;
      end
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{valid: 1'b1, killed: 1'b0,
                         rd: push_rd, data: push_data};
        wr_ptr <= wr_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i].valid && !mem[i].killed) begin
        if (mem[i].rd == q_rs) rs_hit = 1'b1;
        if (mem[i].rd == q_rt) rt_hit = 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: merges pipeline and long-latency
// results onto the single regfile write port.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t     head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          rs_hit;
  logic          rt_hit;
  logic          live;
  logic          push;
  logic          pop;
  logic          pipe_wr;
  wb_sel_e       sel;
  logic [SW-1:0] starve;

  logic              w_en;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;

  assign pipe_wr = bus.p_valid && bus.p_wen &&
                   bus.p_rd != REG_ZERO;

  always_comb begin
    sel = SEL_NONE;
    if (bus.p_stall && !empty)  sel = SEL_FIFO;
    else if (pipe_wr)           sel = SEL_PIPE;
    else if (!empty)            sel = SEL_FIFO;
  end

  assign pop  = (sel == SEL_FIFO);
  assign push = bus.l_valid && bus.l_ready &&
                bus.l_rd != REG_ZERO;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.l_rd),
    .push_data (bus.l_data),
    .pop       (pop),
    .kill_en   (sel == SEL_PIPE),
    .kill_rd   (bus.p_rd),
    .q_rs      (bus.q_rs),
    .q_rt      (bus.q_rt),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .rs_hit    (rs_hit),
    .rt_hit    (rt_hit)
  );

  // ready is held low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_en   <= 1'b0;
      w_rd   <= '0;
      w_data <= '0;
    end else begin
      unique case (sel)
        SEL_PIPE: begin
          w_en   <= 1'b1;
          w_rd   <= bus.p_rd;
          w_data <= bus.p_data;
        end
        SEL_FIFO: begin
          w_en   <= head.valid && !head.killed;
          w_rd   <= head.rd;
          w_data <= head.data;
        end
        default: w_en <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve <= '0;
    else if (full && !pop)
      starve <= (starve == SW'(STARVE_LIMIT)) ?
                starve : starve + SW'(1);
    else
      starve <= '0;
  end

  assign bus.p_stall      = (starve == SW'(STARVE_LIMIT));
  assign bus.l_ready      = live && !full;
  assign bus.fifo_count   = count;
  assign bus.W_en         = w_en;
  assign bus.W_write_rd   = w_rd;
  assign bus.W_write_data = w_data;

  assign bus.q_rs_busy = (bus.q_rs != REG_ZERO) &&
    (rs_hit || (w_en && w_rd == bus.q_rs));
  assign bus.q_rt_busy = (bus.q_rt != REG_ZERO) &&
    (rt_hit || (w_en && w_rd == bus.q_rt));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Drives after each rising edge, checks 1 time unit later.
module tb_wb_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  wb_arbiter_if #(.CW(3)) bus ();

  wb_arbiter #(
    .FIFO_DEPTH   (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst && bus.p_stall && bus.p_valid)
      check("p_valid_during_stall", 32'(bus.p_valid), 32'd0);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.p_valid = 1'b0;
    bus.p_wen   = 1'b1;
    bus.p_rd    = '0;
    bus.p_data  = '0;
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd4;
    bus.l_data  = 32'h4444;
    bus.q_rs    = '0;
    bus.q_rt    = '0;

    tick();
    tick();
    check("rst_w_en",    32'(bus.W_en),       32'd0);
    check("rst_l_ready", 32'(bus.l_ready),    32'd0);
    check("rst_count",   32'(bus.fifo_count), 32'd0);
    check("rst_p_stall", 32'(bus.p_stall),    32'd0);
    bus.l_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rel_l_ready", 32'(bus.l_ready),    32'd1);
    check("rel_count",   32'(bus.fifo_count), 32'd0);

    // pipeline only
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd3;
    bus.p_data  = 32'h1234;
    tick();
    check("pipe_w_en",  32'(bus.W_en),         32'd1);
    check("pipe_rd",    32'(bus.W_write_rd),   32'd3);
    check("pipe_data",  bus.W_write_data,      32'h1234);
    bus.p_rd = 5'd0;
    tick();
    check("pipe_rd0_w_en", 32'(bus.W_en), 32'd0);

    // long-latency under pipeline priority
    bus.p_rd    = 5'd7;
    bus.p_data  = 32'h77;
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd5;
    bus.l_data  = 32'hAAAA;
    bus.q_rs    = 5'd5;
    tick();
    bus.l_valid = 1'b0;
    check("ll_count1",  32'(bus.fifo_count), 32'd1);
    check("ll_busy5",   32'(bus.q_rs_busy),  32'd1);
    check("ll_w_rd7",   32'(bus.W_write_rd), 32'd7);
    tick();
    check("ll_hold_count", 32'(bus.fifo_count), 32'd1);
    bus.p_valid = 1'b0;
    tick();
    check("ll_pop_w_en", 32'(bus.W_en),         32'd1);
    check("ll_pop_rd",   32'(bus.W_write_rd),   32'd5);
    check("ll_pop_data", bus.W_write_data,      32'hAAAA);
    check("ll_count0",   32'(bus.fifo_count),   32'd0);
    check("ll_busy_wr",  32'(bus.q_rs_busy),    32'd1);
    tick();
    check("ll_idle_w_en", 32'(bus.W_en),      32'd0);
    check("ll_busy_clr",  32'(bus.q_rs_busy), 32'd0);

    // WAW kill
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd7;
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd9;
    bus.l_data  = 32'h1111;
    bus.q_rs    = 5'd9;
    tick();
    bus.l_valid = 1'b0;
    check("waw_count1", 32'(bus.fifo_count), 32'd1);
    check("waw_busy_q", 32'(bus.q_rs_busy),  32'd1);
    bus.p_rd   = 5'd9;
    bus.p_data = 32'h2222;
    tick();
    check("waw_pipe_rd",   32'(bus.W_write_rd), 32'd9);
    check("waw_pipe_data", bus.W_write_data,    32'h2222);
    check("waw_busy_w",    32'(bus.q_rs_busy),  32'd1);
    bus.p_valid = 1'b0;
    tick();
    check("waw_kill_w_en", 32'(bus.W_en),         32'd0);
    check("waw_count0",    32'(bus.fifo_count),   32'd0);
    check("waw_busy_clr",  32'(bus.q_rs_busy),    32'd0);

    // fill FIFO under continuous pipeline writes
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd7;
    bus.q_rs    = 5'd12;
    bus.q_rt    = 5'd14;
    for (int i = 0; i < 4; i++) begin
      bus.l_valid = 1'b1;
      bus.l_rd    = 5'(10 + i);
      bus.l_data  = 32'hA0 + 32'(i);
      tick();
    end
    bus.l_rd   = 5'd14;
    bus.l_data = 32'hEE;
    check("full_count",   32'(bus.fifo_count), 32'd4);
    check("full_l_ready", 32'(bus.l_ready),    32'd0);
    check("full_rs_busy", 32'(bus.q_rs_busy),  32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("starve_%0d", i),
            32'(bus.p_stall), (i == 8) ? 32'd1 : 32'd0);
    end
    check("starve_count", 32'(bus.fifo_count), 32'd4);
    check("starve_rt_free", 32'(bus.q_rt_busy), 32'd0);
    bus.p_valid = 1'b0;
    bus.l_valid = 1'b0;
    tick();
    check("stall_pop_w_en", 32'(bus.W_en),       32'd1);
    check("stall_pop_rd",   32'(bus.W_write_rd), 32'd10);
    check("stall_pop_data", bus.W_write_data,    32'hA0);
    check("stall_clr",      32'(bus.p_stall),    32'd0);
    check("stall_count3",   32'(bus.fifo_count), 32'd3);
    check("stall_l_ready",  32'(bus.l_ready),    32'd1);

    // push to r0 completes but is not enqueued
    bus.p_valid = 1'b1;
    bus.p_rd    = 5'd7;
    bus.l_valid = 1'b1;
    bus.l_rd    = 5'd0;
    tick();
    bus.l_valid = 1'b0;
    check("r0_push_count", 32'(bus.fifo_count), 32'd3);
    check("r0_w_en_pipe",  32'(bus.W_en),       32'd1);

    // asynchronous mid-operation reset
    bus.p_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("mrst_w_en",    32'(bus.W_en),       32'd0);
    check("mrst_count",   32'(bus.fifo_count), 32'd0);
    check("mrst_l_ready", 32'(bus.l_ready),    32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_w_en",    32'(bus.W_en),       32'd0);
    check("post_count",   32'(bus.fifo_count), 32'd0);
    check("post_l_ready", 32'(bus.l_ready),    32'd1);
    tick();
    check("post_w_en2",   32'(bus.W_en),       32'd0);
    check("post_busy",    32'(bus.q_rs_busy),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage that sits directly upstream of the register file and drives its single write port (W_write_rd / W_write_data / W_en). It merges two result sources:
- the in-order pipeline (MEM/WB results), which cannot stall and has priority;
- a long-latency unit (mult/div, uncached load), which uses a valid/ready handshake and is buffered in a small FIFO.

It also reports pending-write hazards to decode. The regfile has no write-to-read bypass, so decode must stall on these.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
FIFO_DEPTH, 4, long-latency result buffer entries (power of two, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles at full FIFO before p_stall is requested

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
p_valid  input  1  pipeline result present this cycle
p_wen  input  1  pipeline result writes a register
p_rd  input  ADDR_W  pipeline destination
p_data  input  DATA_W  pipeline result
p_stall  output  1  request upstream pipeline to hold p_valid low
l_valid  input  1  long-latency result offered
l_ready  output  1  FIFO can accept
l_rd  input  ADDR_W  long-latency destination
l_data  input  DATA_W  long-latency result
q_rs  input  ADDR_W  decode source index 1
q_rt  input  ADDR_W  decode source index 2
q_rs_busy  output  1  write to q_rs pending
q_rt_busy  output  1  write to q_rt pending
W_write_rd  output  ADDR_W  to regfile
W_write_data  output  DATA_W  to regfile
W_en  output  1  to regfile
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (rst=0, asynchronous): W_en=0, W_write_rd=0, W_write_data=0, FIFO empty, fifo_count=0, starve counter=0, p_stall=0, l_ready=0. While rst=1, l_ready = (fifo_count != FIFO_DEPTH).
- Reset asserted mid-operation discards all FIFO contents and any pending output write. No partial write is produced.
- Output register: W_* are registered. A result accepted in cycle N appears on W_* in cycle N+1. The regfile commits it at the end of cycle N+1.
- Per-cycle selection, evaluated in order:
  1. If p_stall=1 and the FIFO is not empty, pop the head.
  2. Else if p_valid && p_wen && p_rd != 0, load the pipeline result.
  3. Else if the FIFO is not empty, pop the head.
  4. Else W_en <= 0.
- A popped head that is killed loads W_en <= 0 (the slot is consumed, no write).
- rd = 0:
  - never produces W_en=1;
  - a pipeline write to 0 counts as "no pipeline write";
  - a long-latency push with l_rd=0 is accepted (handshake completes) but is not enqueued.
- Long-latency handshake: push occurs when l_valid && l_ready. l_ready depends only on the registered count, not on a same-cycle pop, so a full FIFO refuses a push even while popping. A push and a pop in the same cycle leave the count unchanged.
- WAW ordering:
  - When a pipeline write to rd X is selected, every entry already in the FIFO with rd X is marked killed.
  - An entry pushed in the same cycle is not killed; it is newer.
- Starvation guard:
  - The starve counter increments each cycle the FIFO is full and its head is not popped.
  - It clears on any pop or when the FIFO is not full, and saturates at STARVE_LIMIT.
  - p_stall = (counter == STARVE_LIMIT).
  - Upstream must drive p_valid=0 while p_stall=1. If p_valid=1 during p_stall, that pipeline result is dropped; this is a protocol violation and the bench flags it.
- Hazard query: q_x_busy=1 when q_x != 0 and q_x matches any of:
  - the rd of a valid, non-killed FIFO entry;
  - W_write_rd while W_en=1.
  This is combinational from state only.
- FIFO: circular buffer with wrap-around read/write pointers. Each entry holds a valid bit, a killed bit, rd and data. fifo_count counts entries including killed ones.

Decomposition:
- Shared package: DATA_W/ADDR_W constants, REG_ZERO index constant, and a wb_entry record (valid, killed, rd, data) typedef.
- One sub-module: wb_fifo (circular buffer with per-entry kill-by-rd match and a parallel rd-match port for hazard query). Arbitration, starvation counter and output register stay in wb_arbiter.

Test Plan:
- Reset: hold rst=0 with l_valid=1 -> W_en=0, l_ready=0, fifo_count=0. Release -> l_ready=1 next cycle.
- Pipeline only: p_valid=1, p_rd=3, p_data=0x1234 in cycle N -> W_en=1, W_write_rd=3, W_write_data=0x1234 in cycle N+1. Same stimulus with p_rd=0 -> W_en=0.
- Long-latency with priority:
  - Push l_rd=5/0xAAAA while pipeline writes r7 continuously -> fifo_count=1 and q_rs=5 busy.
  - Drop p_valid -> r5 write appears the next cycle, fifo_count=0, busy clears after the write cycle.
- WAW kill: FIFO holds rd=9/0x1111, pipeline writes rd=9/0x2222 -> regfile receives only 0x2222. The killed entry pops with W_en=0 and q_rs_busy(9) drops after the pipeline write.
- Full FIFO and starvation: push 4 entries with p_valid held high -> l_ready=0. After 8 blocked cycles p_stall=1 and the head pops while p_valid=0. p_stall clears on the pop and l_ready returns the next cycle.
- Mid-operation reset with fifo_count=3 -> immediate W_en=0 and fifo_count=0; no stale write after release.
